// File: rtl/ex_hazard_ctrl.sv
// ============================================================================
// ex_hazard_ctrl
// ----------------------------------------------------------------------------
// Hazard sequencer for the execute stage. It sits next to the ID/EX, EX/MEM
// and MEM/WB pipeline registers. It keeps its own small shadow copy of the
// destination information held in EX, MEM and WB, and uses that copy to:
//   * produce registered operand-forwarding selects for the instruction in EX
//     (0 = register file, 1 = MEM-stage result, 2 = WB-stage result);
//   * insert a load-use bubble when ID needs the result of a load in EX;
//   * flush the two wrong-path instructions after a taken branch;
//   * freeze the back half of the pipe while data memory is not ready.
//
// Optional feature (compile-time macro HAZARD_PERF_EN):
//   Adds three saturating performance counters: cnt_loaduse, cnt_flush and
//   cnt_wait. Without the macro these ports and counters do not exist.
//
// Parameters:
//   RA_W   register-address width
//   CNT_W  performance-counter width (used only with HAZARD_PERF_EN)
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_rs, id_rt      ID source registers
//   id_use_rs/_rt     ID instruction reads rs / rt
//   id_dest           ID resolved write target
//   id_regwrite       ID instruction writes the register file
//   id_memread        ID instruction is a load
//   id_memop          ID instruction accesses data memory
//   branch_taken      EX resolved a taken branch or jump this cycle
//   mem_ready         data memory completes the MEM access this cycle
//   stall_pc          hold the PC
//   stall_ifid        hold IF/ID
//   bubble_idex       load a NOP into ID/EX at the next edge
//   flush_ifid        load a NOP into IF/ID at the next edge
//   freeze            hold ID/EX, EX/MEM and MEM/WB
//   ControlA/B        registered forward selects for operands A/B in EX
//   cnt_*             performance counters (HAZARD_PERF_EN only)
//   dbg_state         current sequencer state (RUN=0, WAIT=1, FLUSH=2)
//   dbg_wb            WB shadow {valid, dest, regwrite, memread, memop}
//
// Handshake/timing: every control output is combinational from the current
// shadows, the sequencer state and the ID/EX inputs, and is consumed by the
// pipeline registers at the next rising edge. ControlA/ControlB change only on
// edges where the pipe advances (freeze=0) and hold otherwise. While reset is
// high every output reads 0.
// ============================================================================
module ex_hazard_ctrl #(
    parameter int RA_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RA_W-1:0]  id_dest,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memop,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             freeze,
    output logic [1:0]       ControlA,
    output logic [1:0]       ControlB,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] cnt_loaduse,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_wait,
`endif
    output logic [1:0]       dbg_state,
    output logic [RA_W+3:0]  dbg_wb
);

    // ------------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // ------------------------------------------------------------------------
    // Shadow copies of the destination info held in EX, MEM and WB
    // ------------------------------------------------------------------------
    logic            ex_valid;
    logic [RA_W-1:0] ex_dest;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memop;

    logic            mem_valid;
    logic [RA_W-1:0] mem_dest;
    logic            mem_regwrite;
    logic            mem_memread;
    logic            mem_memop;

    logic            wb_valid;
    logic [RA_W-1:0] wb_dest;
    logic            wb_regwrite;
    logic            wb_memread;
    logic            wb_memop;

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    logic mem_wait;
    logic load_use;

    // A memory access sitting in MEM that has not completed stalls everything.
    assign mem_wait = mem_valid & mem_memop & ~mem_ready;

    // ID needs the result of a load that is still in EX.
    assign load_use = ex_valid & ex_memread & ex_regwrite & id_valid &
                      ((id_use_rs & (id_rs == ex_dest)) |
                       (id_use_rt & (id_rt == ex_dest)));

    // ------------------------------------------------------------------------
    // Next state and raw control outputs (before reset gating)
    // ------------------------------------------------------------------------
    logic stall_int;
    logic bubble_int;
    logic flush_int;
    logic freeze_int;
    logic loaduse_drv;

    always_comb begin
        state_nxt   = S_RUN;
        stall_int   = 1'b0;
        bubble_int  = 1'b0;
        flush_int   = 1'b0;
        freeze_int  = 1'b0;
        loaduse_drv = 1'b0;

        if (mem_wait) begin
            // Memory not ready wins over everything; a pending second flush
            // cycle is dropped because the branch is still frozen in EX.
            freeze_int = 1'b1;
            stall_int  = 1'b1;
            state_nxt  = S_WAIT;
        end else if (state == S_FLUSH) begin
            // Second wrong-path kill cycle; a new branch_taken is ignored.
            flush_int  = 1'b1;
            bubble_int = 1'b1;
            state_nxt  = S_RUN;
        end else if (branch_taken) begin
            // PC is not held so that it loads the branch target.
            flush_int  = 1'b1;
            bubble_int = 1'b1;
            state_nxt  = S_FLUSH;
        end else if (load_use) begin
            stall_int   = 1'b1;
            bubble_int  = 1'b1;
            loaduse_drv = 1'b1;
            state_nxt   = S_RUN;
        end else begin
            state_nxt = S_RUN;
        end
    end

    // Outputs are forced low for as long as reset is high, independent of clk.
    assign stall_pc    = ~reset & stall_int;
    assign stall_ifid  = ~reset & stall_int;
    assign bubble_idex = ~reset & bubble_int;
    assign flush_ifid  = ~reset & flush_int;
    assign freeze      = ~reset & freeze_int;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Shadow pipeline: advances whenever the real pipe advances
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_dest      <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_memop     <= 1'b0;
            mem_valid    <= 1'b0;
            mem_dest     <= '0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memop    <= 1'b0;
            wb_valid     <= 1'b0;
            wb_dest      <= '0;
            wb_regwrite  <= 1'b0;
            wb_memread   <= 1'b0;
            wb_memop     <= 1'b0;
        end else if (!freeze_int) begin
            if (bubble_int) begin
                // A bubble enters EX with all control bits cleared.
                ex_valid    <= 1'b0;
                ex_dest     <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_memop    <= 1'b0;
            end else begin
                ex_valid    <= id_valid;
                ex_dest     <= id_dest;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
                ex_memop    <= id_memop;
            end
            mem_valid    <= ex_valid;
            mem_dest     <= ex_dest;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            mem_memop    <= ex_memop;
            wb_valid     <= mem_valid;
            wb_dest      <= mem_dest;
            wb_regwrite  <= mem_regwrite;
            wb_memread   <= mem_memread;
            wb_memop     <= mem_memop;
        end
    end

    // ------------------------------------------------------------------------
    // Forwarding selects for the instruction about to enter EX.
    // The producer now in EX will be in MEM when the consumer executes
    // (select 1); the producer now in MEM will be in WB (select 2). The EX
    // match is checked first so the youngest producer wins.
    // ------------------------------------------------------------------------
    logic       ex_hit_a;
    logic       mem_hit_a;
    logic       ex_hit_b;
    logic       mem_hit_b;
    logic [1:0] ctl_a_nxt;
    logic [1:0] ctl_b_nxt;

    assign ex_hit_a  = id_use_rs & ex_valid  & ex_regwrite  & (ex_dest  == id_rs);
    assign mem_hit_a = id_use_rs & mem_valid & mem_regwrite & (mem_dest == id_rs);
    assign ex_hit_b  = id_use_rt & ex_valid  & ex_regwrite  & (ex_dest  == id_rt);
    assign mem_hit_b = id_use_rt & mem_valid & mem_regwrite & (mem_dest == id_rt);

    always_comb begin
        ctl_a_nxt = 2'd0;
        ctl_b_nxt = 2'd0;
        if (ex_hit_a) begin
            ctl_a_nxt = 2'd1;
        end else if (mem_hit_a) begin
            ctl_a_nxt = 2'd2;
        end
        if (ex_hit_b) begin
            ctl_b_nxt = 2'd1;
        end else if (mem_hit_b) begin
            ctl_b_nxt = 2'd2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ControlA <= 2'd0;
            ControlB <= 2'd0;
        end else if (!freeze_int) begin
            if (bubble_int) begin
                ControlA <= 2'd0;
                ControlB <= 2'd0;
            end else begin
                ControlA <= ctl_a_nxt;
                ControlB <= ctl_b_nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional saturating performance counters
    // ------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_loaduse <= '0;
            cnt_flush   <= '0;
            cnt_wait    <= '0;
        end else begin
            if (loaduse_drv && (cnt_loaduse != '1)) begin
                cnt_loaduse <= cnt_loaduse + CNT_W'(1);
            end
            // Counts both the branch cycle and the following FLUSH cycle.
            if (flush_int && (cnt_flush != '1)) begin
                cnt_flush <= cnt_flush + CNT_W'(1);
            end
            if (mem_wait && (cnt_wait != '1)) begin
                cnt_wait <= cnt_wait + CNT_W'(1);
            end
        end
    end
`else
    // Without the counters the load-use indicator has no consumer.
    logic loaduse_unused;
    assign loaduse_unused = loaduse_drv;
`endif

    // ------------------------------------------------------------------------
    // Debug visibility
    // ------------------------------------------------------------------------
    assign dbg_state = state;
    assign dbg_wb    = {wb_valid, wb_dest, wb_regwrite, wb_memread, wb_memop};

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Pipeline sequencer for the execute stage and its operand-forwarding muxes.
- Keeps shadow copies of EX/MEM/WB destination info, which it uses to:
  - generate registered forwarding selects (ControlA/ControlB: 0 = regfile, 1 = MEM result, 2 = WB result);
  - insert load-use bubbles;
  - flush on taken branch;
  - freeze the pipe while data memory is not ready.
- Sits beside the ID/EX, EX/MEM and MEM/WB registers and drives their hold/bubble controls.

Parameters:
- RA_W, 2, register-address width.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  RA_W  ID source register 1.
- id_rt  in  RA_W  ID source register 2.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt (ALUSrc=0 or store).
- id_dest  in  RA_W  ID resolved write target.
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- id_memop  in  1  ID instruction accesses data memory (load or store).
- branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- mem_ready  in  1  data memory completes the access in MEM this cycle.
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID.
- bubble_idex  out  1  load NOP (all control 0) into ID/EX at the next edge.
- flush_ifid  out  1  load NOP into IF/ID at the next edge.
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- ControlA  out  2  forward select for operand A of the instruction in EX (registered).
- ControlB  out  2  forward select for operand B (registered).

Behaviour:
- Reset: all outputs 0; state RUN; all shadow valid bits 0. Takes effect immediately, independent of clk.
- Shadow stages: ex_*, mem_*, wb_*. Each holds {valid, dest, regwrite, memread, memop}.
  - Advance on every edge with freeze=0: id->ex, ex->mem, mem->wb.
  - When bubble_idex=1, ex_valid becomes 0.
  - When freeze=1, all shadows hold.
- mem_wait = mem_valid & mem_memop & ~mem_ready (combinational).
- load_use = ex_valid & ex_memread & ex_regwrite & id_valid & ((id_use_rs & id_rs==ex_dest) | (id_use_rt & id_rt==ex_dest)).
- Combinational priority, highest first:
  - 1) mem_wait: freeze=stall_pc=stall_ifid=1; no bubble, no flush.
  - 2) branch_taken: flush_ifid=1, bubble_idex=1; stall_pc=0, so the PC takes the target.
  - 3) load_use: stall_pc=stall_ifid=bubble_idex=1.
  - 4) otherwise all 0.
- FSM:
  - RUN -> WAIT when mem_wait.
  - RUN -> FLUSH when branch_taken and not mem_wait.
  - WAIT -> RUN on the first cycle mem_wait=0. A branch_taken sampled in that cycle is honoured then.
  - FLUSH: one cycle with flush_ifid=1 and bubble_idex=1, killing the second wrong-path instruction. branch_taken is ignored in FLUSH. Returns to RUN, or goes to WAIT if mem_wait.
- Forwarding:
  - On each advancing edge (freeze=0, bubble_idex=0), the selects for the instruction entering EX are computed from pre-edge shadows:
    - ControlA = 1 if id_use_rs & ex_valid & ex_regwrite & ex_dest==id_rs;
    - else 2 if the same match holds on mem_*;
    - else 0.
    - ControlB is the same for rt with id_use_rt.
  - EX-stage match wins over MEM-stage match (youngest producer).
  - On a bubble edge, ControlA=ControlB=0.
  - When freeze=1, the selects hold.
- A load that is one stage ahead never reaches the select-1 path, because the load_use bubble forces it to select 2.
- Register $0 is not special; all registers are forwardable.
- WB-to-ID same-cycle reads are the register file's responsibility; they are not forwarded here.
- Reset asserted mid-stall or mid-flush: immediate return to the reset state; no pending flush survives.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined: adds output ports cnt_loaduse, cnt_flush and cnt_wait, each CNT_W bits.
  - Each counts the cycles in which its condition drove the outputs (flush counts both flush cycles).
  - Counters saturate at all-ones; reset clears them to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ADD r1 in EX, then SUB r2,r1,r3 in ID, no stall -> next edge ControlA=1, ControlB=0.
- LWD r1 in EX, ADD using r1 as rt in ID -> one cycle stall_pc=stall_ifid=bubble_idex=1; after two edges ControlB=2 and the stall is released.
- Producers of r2 in both EX and MEM, consumer reads r2 -> ControlA=1 (youngest wins).
- branch_taken=1 in RUN -> flush_ifid=bubble_idex=1 for exactly 2 cycles, stall_pc=0; ControlA=ControlB=0 afterwards.
- Store in MEM with mem_ready low for 3 cycles, concurrent load_use -> freeze=1 for 3 cycles with no bubble and selects held; the load-use bubble is issued in cycle 4.
- Reset pulsed during FLUSH -> all outputs 0 immediately; no flush in the cycle after release.
